// File: rtl/wb_cmd_master_if.sv
// Command/response streams, Wishbone classic bus and interrupt lines of wb_cmd_master.
// The master modport is the wb_cmd_master view; slave is the command source / bus slave side.
interface wb_cmd_master_if #(
   parameter int ADDR_W = 32'd3,
   parameter int DATA_W = 32'd8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic [ADDR_W-1:0] wb_adr_o;
   logic [DATA_W-1:0] wb_dat_o;
   logic [DATA_W-1:0] wb_dat_i;
   logic              wb_we_o;
   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic              wb_ack_i;
   logic              wb_inta_i;
   logic              irq_o;
   logic              irq_pulse_o;

   modport master (
      input  cmd_valid, cmd_we, cmd_addr, cmd_data, rsp_ready, wb_dat_i, wb_ack_i, wb_inta_i,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, wb_adr_o, wb_dat_o, wb_we_o,
             wb_cyc_o, wb_stb_o, irq_o, irq_pulse_o
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_addr, cmd_data, rsp_ready, wb_dat_i, wb_ack_i, wb_inta_i,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, wb_adr_o, wb_dat_o, wb_we_o,
             wb_cyc_o, wb_stb_o, irq_o, irq_pulse_o
   );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic master: queued read/write commands, one bus cycle and one in-order
// response per command, ack timeout, and a registered interrupt with rising-edge pulse.
module wb_cmd_master #(
   parameter int          ADDR_W     = 32'd3,
   parameter int          DATA_W     = 32'd8,
   parameter int          FIFO_DEPTH = 32'd4,
   parameter int unsigned TIMEOUT    = 32'd255
) (
   input  logic            clk,
   input  logic            rst,
   wb_cmd_master_if.master bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 1 + ADDR_W + DATA_W;
   localparam int TMO_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 32'd0) ? (TIMEOUT - 32'd1) : 32'd0);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   logic [ENT_W-1:0]  fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_next_s;
   logic              cmd_ready_r;
   logic              push_s;
   logic              pop_s;
   logic              empty_s;
   state_t            state_r;
   state_t            state_next_s;
   logic              ack_hit_s;
   logic              tmo_hit_s;
   logic [TMO_W-1:0]  tmo_cnt_r;
   logic [ADDR_W-1:0] adr_r;
   logic [DATA_W-1:0] dat_r;
   logic              we_r;
   logic              cyc_r;
   logic              rsp_valid_r;
   logic [DATA_W-1:0] rsp_data_r;
   logic              rsp_err_r;
   logic              irq_r;
   logic              irq_pulse_r;

   // cmd_ready is registered, so a pop in a full cycle cannot let a push through.
   assign push_s  = bus.cmd_valid & cmd_ready_r;
   assign empty_s = (count_r == {CNT_W{1'b0}});

   // FIFO occupancy after this edge's push/pop.
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CNT_W'(1'b1);
         2'b01:   count_next_s = count_r - CNT_W'(1'b1);
         default: count_next_s = count_r;
      endcase
   end

   // Command storage; entries are qualified by the pointers, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= {bus.cmd_we, bus.cmd_addr, bus.cmd_data};
      end
   end

   // FIFO pointers, occupancy and the registered ready flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         cmd_ready_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         count_r     <= count_next_s;
         cmd_ready_r <= (count_next_s != CNT_FULL);
      end
   end

   // Next-state, FIFO pop and bus-termination decode; ack takes priority over timeout.
   always_comb begin
      state_next_s = state_r;
      pop_s        = 1'b0;
      ack_hit_s    = 1'b0;
      tmo_hit_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s) begin
               pop_s        = 1'b1;
               state_next_s = ST_BUS;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_BUS: begin
            if (bus.wb_ack_i) begin
               ack_hit_s    = 1'b1;
               state_next_s = ST_RESP;
            end else if ((TIMEOUT != 32'd0) && (tmo_cnt_r == TMO_LAST)) begin
               tmo_hit_s    = 1'b1;
               state_next_s = ST_RESP;
            end else begin
               state_next_s = ST_BUS;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready && !empty_s) begin
               pop_s        = 1'b1;
               state_next_s = ST_BUS;
            end else if (bus.rsp_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RESP;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register, bus/response output registers and ack-wait counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cyc_r       <= 1'b0;
         rsp_valid_r <= 1'b0;
         adr_r       <= {ADDR_W{1'b0}};
         dat_r       <= {DATA_W{1'b0}};
         we_r        <= 1'b0;
         tmo_cnt_r   <= {TMO_W{1'b0}};
         rsp_data_r  <= {DATA_W{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         cyc_r       <= (state_next_s == ST_BUS);
         rsp_valid_r <= (state_next_s == ST_RESP);
         if (pop_s) begin
            {we_r, adr_r, dat_r} <= fifo_mem_r[rd_ptr_r];
            tmo_cnt_r            <= {TMO_W{1'b0}};
         end else if (state_r == ST_BUS) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
         end
         if (ack_hit_s) begin
            rsp_data_r <= we_r ? {DATA_W{1'b0}} : bus.wb_dat_i;
            rsp_err_r  <= 1'b0;
         end else if (tmo_hit_s) begin
            rsp_data_r <= {DATA_W{1'b0}};
            rsp_err_r  <= 1'b1;
         end
      end
   end

   // Interrupt level register and its rising-edge pulse, independent of the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_r       <= 1'b0;
         irq_pulse_r <= 1'b0;
      end else begin
         irq_r       <= bus.wb_inta_i;
         irq_pulse_r <= bus.wb_inta_i & ~irq_r;
      end
   end

   assign bus.cmd_ready   = cmd_ready_r;
   assign bus.rsp_valid   = rsp_valid_r;
   assign bus.rsp_data    = rsp_data_r;
   assign bus.rsp_err     = rsp_err_r;
   assign bus.wb_adr_o    = adr_r;
   assign bus.wb_dat_o    = dat_r;
   assign bus.wb_we_o     = we_r;
   assign bus.wb_cyc_o    = cyc_r;
   assign bus.wb_stb_o    = cyc_r;
   assign bus.irq_o       = irq_r;
   assign bus.irq_pulse_o = irq_pulse_r;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a command-order reference model.
module tb_wb_cmd_master;
   localparam int ADDR_W     = 3;
   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 8;
   localparam int NEVER      = 1000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   wb_cmd_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } bus_cmd_t;
   typedef struct { logic [DATA_W-1:0] data; logic err; } rsp_t;
   typedef struct {
      logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; int delay;
      logic [DATA_W-1:0] exp_data; logic exp_err;
   } vec_t;

   bus_cmd_t bus_q [$];
   int       delay_q [$];
   rsp_t     rsp_q [$];
   int       gap_q [$];
   logic [DATA_W-1:0] slave_regs [8];
   logic [DATA_W-1:0] model_mem [8];

   int checks = 0;
   int errors = 0;
   int rsp_mode = 0;
   bit abort_ok = 1'b0;

   // slave bookkeeping
   bit       prev_cyc = 1'b0;
   int       age = 0;
   int       cur_delay = 0;
   int       gap = 0;
   bus_cmd_t cur;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: commands take effect in acceptance order; a non-acked cycle changes nothing.
   function automatic rsp_t model(input logic we, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] d, input int delay);
      rsp_t r;
      if (delay >= TIMEOUT) begin
         r.data = '0; r.err = 1'b1;
      end else if (we) begin
         model_mem[a] = d; r.data = '0; r.err = 1'b0;
      end else begin
         r.data = model_mem[a]; r.err = 1'b0;
      end
      return r;
   endfunction

   // Wishbone slave: acks after the per-command delay, checks held signals and cycle length.
   initial begin
      bus.wb_ack_i = 1'b0;
      bus.wb_dat_i = '0;
      forever begin
         @(posedge clk); #1;
         if (bus.wb_cyc_o === 1'b1) begin
            if (!prev_cyc) begin
               gap_q.push_back(gap);
               gap = 0;
               age = 0;
               if (bus_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_cycle actual adr=%0h expected no bus cycle", bus.wb_adr_o);
                  cur = '{1'b0, '0, '0};
                  cur_delay = NEVER;
               end else begin
                  cur = bus_q.pop_front();
                  cur_delay = delay_q.pop_front();
               end
            end else begin
               age++;
            end
            check("stb_eq_cyc", bus.wb_stb_o, 1'b1);
            check("wb_adr", bus.wb_adr_o, cur.addr);
            check("wb_we", bus.wb_we_o, cur.we);
            check("wb_dat_o", bus.wb_dat_o, cur.data);
            bus.wb_ack_i = (age == cur_delay);
            if (bus.wb_ack_i && cur.we) slave_regs[cur.addr] = cur.data;
            bus.wb_dat_i = (bus.wb_ack_i && !cur.we) ? slave_regs[cur.addr]
                                                     : DATA_W'($urandom_range(1, 255));
         end else begin
            if (prev_cyc && !abort_ok)
               check("cyc_len", age + 1, (cur_delay < TIMEOUT) ? cur_delay + 1 : TIMEOUT);
            check("stb_idle", bus.wb_stb_o, 1'b0);
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = DATA_W'($urandom_range(1, 255));
            gap++;
         end
         prev_cyc = (bus.wb_cyc_o === 1'b1);
      end
   end

   // Response consumer: drives rsp_ready per mode and scores each handshake in order.
   initial begin
      logic r;
      rsp_t e;
      bus.rsp_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rsp_mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            default: r = 1'($urandom_range(0, 1));
         endcase
         bus.rsp_ready = r;
         if (!rst && bus.rsp_valid === 1'b1 && r) begin
            if (rsp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rsp actual data=%0h err=%0b expected none",
                        bus.rsp_data, bus.rsp_err);
            end else begin
               e = rsp_q.pop_front();
               check("rsp_data", bus.rsp_data, e.data);
               check("rsp_err", bus.rsp_err, e.err);
            end
         end
      end
   end

   task automatic send(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                       input int delay, input logic [DATA_W-1:0] ed, input logic ee);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_we    = we;
      bus.cmd_addr  = addr;
      bus.cmd_data  = data;
      while (bus.cmd_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.cmd_ready === 1'b1) begin
         bus_q.push_back('{we, addr, data});
         delay_q.push_back(delay);
         rsp_q.push_back('{ed, ee});
         @(posedge clk); #1;
      end else begin
         check("cmd_accept_bound", bus.cmd_ready, 1'b1);
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((rsp_q.size() != 0 || bus.wb_cyc_o === 1'b1 || bus.rsp_valid === 1'b1) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_drain"}, rsp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=still running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [9];
      rsp_t e;
      int   pulses;
      int   n;

      for (int i = 0; i < 8; i++) begin
         slave_regs[i] = DATA_W'(8'h10 * i);
         model_mem[i]  = DATA_W'(8'h10 * i);
      end
      slave_regs[5] = 8'h3C;
      model_mem[5]  = 8'h3C;

      vecs[0] = '{1'b1, 3'd3, 8'hA5, 2,           8'h00, 1'b0};
      vecs[1] = '{1'b0, 3'd5, 8'h00, 0,           8'h3C, 1'b0};
      vecs[2] = '{1'b0, 3'd3, 8'h00, 1,           8'hA5, 1'b0};
      vecs[3] = '{1'b1, 3'd7, 8'h5A, NEVER,       8'h00, 1'b1};
      vecs[4] = '{1'b0, 3'd7, 8'h00, 3,           8'h70, 1'b0};
      vecs[5] = '{1'b0, 3'd2, 8'h00, TIMEOUT - 1, 8'h20, 1'b0};
      vecs[6] = '{1'b0, 3'd2, 8'h00, TIMEOUT,     8'h00, 1'b1};
      vecs[7] = '{1'b1, 3'd0, 8'hFF, 0,           8'h00, 1'b0};
      vecs[8] = '{1'b0, 3'd0, 8'h00, 0,           8'hFF, 1'b0};

      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
      bus.wb_inta_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", bus.cmd_ready, 1'b0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_rsp_data", bus.rsp_data, 8'h00);
      check("rst_rsp_err", bus.rsp_err, 1'b0);
      check("rst_cyc", bus.wb_cyc_o, 1'b0);
      check("rst_we", bus.wb_we_o, 1'b0);
      check("rst_adr", bus.wb_adr_o, 3'd0);
      check("rst_dat", bus.wb_dat_o, 8'h00);
      check("rst_irq", bus.irq_o, 1'b0);
      check("rst_irq_pulse", bus.irq_pulse_o, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);

      // directed vectors, one at a time
      rsp_mode = 1;
      for (int i = 0; i < 9; i++) begin
         e = model(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].delay);
         send(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].delay, vecs[i].exp_data, vecs[i].exp_err);
         wait_drain("vec");
      end

      // five queued commands with a stalled consumer, one of them timing out
      rsp_mode = 0;
      gap_q.delete();
      for (int i = 0; i < 5; i++) begin
         logic [ADDR_W-1:0] a;
         int dl;
         a  = ADDR_W'(i + 1);
         dl = (i == 2) ? NEVER : i % 3;
         e  = model(i[0], a, DATA_W'(8'hC0 + i), dl);
         send(i[0], a, DATA_W'(8'hC0 + i), dl, e.data, e.err);
      end
      check("full_cmd_ready", bus.cmd_ready, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      check("full_cmd_ready_hold", bus.cmd_ready, 1'b0);
      check("stall_rsp_valid", bus.rsp_valid, 1'b1);
      rsp_mode = 1;
      wait_drain("five");
      check("five_cycles", gap_q.size(), 5);
      for (int i = 2; i < 5; i++)
         if (i < gap_q.size()) check("b2b_gap", gap_q[i], 1);

      // reset while a cycle is active with two commands queued
      rsp_mode = 0;
      for (int i = 0; i < 3; i++) send(1'b0, 3'd4, 8'h00, NEVER, 8'h00, 1'b1);
      n = 0;
      while (bus.wb_cyc_o !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      check("pre_rst_cyc", bus.wb_cyc_o, 1'b1);
      abort_ok = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_cyc", bus.wb_cyc_o, 1'b0);
      check("midrst_stb", bus.wb_stb_o, 1'b0);
      check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
      bus_q.delete(); delay_q.delete(); rsp_q.delete();
      rst = 1'b0;
      @(posedge clk); #1;
      abort_ok = 1'b0;
      check("midrst_cmd_ready", bus.cmd_ready, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("quiet_cyc", bus.wb_cyc_o, 1'b0);
         check("quiet_rsp_valid", bus.rsp_valid, 1'b0);
      end

      // interrupt rising edge held for 10 cycles
      bus.wb_inta_i = 1'b1;
      check("irq_before", bus.irq_o, 1'b0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            check("irq_rise", bus.irq_o, 1'b1);
            check("irq_pulse_first", bus.irq_pulse_o, 1'b1);
         end
         pulses += int'(bus.irq_pulse_o);
      end
      check("irq_hold", bus.irq_o, 1'b1);
      check("irq_pulse_count", pulses, 1);
      bus.wb_inta_i = 1'b0;
      @(posedge clk); #1;
      check("irq_fall", bus.irq_o, 1'b0);
      check("irq_fall_pulse", bus.irq_pulse_o, 1'b0);

      // randomized traffic against the reference model
      rsp_mode = 2;
      for (int i = 0; i < 80; i++) begin
         logic              we;
         logic [ADDR_W-1:0] a;
         logic [DATA_W-1:0] d;
         int                dl;
         we = 1'($urandom_range(0, 1));
         a  = ADDR_W'($urandom_range(0, 7));
         d  = DATA_W'($urandom);
         dl = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT));
         e  = model(we, a, d, dl);
         send(we, a, d, dl, e.data, e.err);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      wait_drain("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
